wb_farbborg_loader: RTL and testbench

Wishbone master that writes a streamed byte sequence into the farbborg frame buffer, one single-beat write cycle per byte, with automatic address increment and wrap. It sits between a byte source (UART receiver, SPI bridge or CPU FIFO) and the farbborg Wishbone slave, acting as the initiator for the slave's write port. It watchdogs each cycle and reports frame completion and timeouts.

---
 rtl/wb_farbborg_pkg.sv | 18 +
 rtl/wb_farbborg_loader.sv | 120 ++++++++++++
 tb/tb_wb_farbborg_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/wb_farbborg_pkg.sv
// Shared types, defaults and helpers for the farbborg frame-buffer loader.
package wb_farbborg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    localparam int unsigned FRAME_LEN_DEF = 375;  // 5x5x5 voxels x RGB
    localparam int unsigned ADR_W_DEF     = 13;
    localparam int unsigned WD_W          = 16;   // watchdog counter width

    // One-hot Wishbone byte select for an 8-bit write into a 32-bit lane.
    function automatic logic [3:0] sel_onehot(input logic [1:0] adr_lo);
        return 4'b0001 << adr_lo;
    endfunction

endpackage

// File: rtl/wb_farbborg_loader.sv
// Wishbone master that writes a byte stream into the farbborg frame buffer,
// one single-beat write per byte, with address auto-increment, frame wrap and
// a per-cycle ack watchdog.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | s_ready high, bus idle, waiting for a byte
//   ST_WRITE | cyc/stb/we high with adr/dat held, waiting for ack or timeout
module wb_farbborg_loader
    import wb_farbborg_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned BASE_ADR  = 0,
    parameter int unsigned ADR_W     = ADR_W_DEF,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_sof,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [7:0]       wb_dat_o,
    output logic [3:0]       wb_sel_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    input  logic             wb_ack_i,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout
);

    localparam logic [ADR_W-1:0] BASE    = ADR_W'(BASE_ADR);
    localparam logic [ADR_W-1:0] LAST    = ADR_W'(FRAME_LEN - 1);
    // Down-counter: loaded on accept, terminal count 0 lands on edge N+TIMEOUT.
    localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [ADR_W-1:0] ptr, ptr_nxt;      // offset the next non-sof byte goes to
    logic [ADR_W-1:0] off, off_nxt;      // offset of the byte in flight
    logic [ADR_W-1:0] adr_q, adr_nxt;
    logic [7:0]       dat_q, dat_nxt;
    logic [WD_W-1:0]  wd, wd_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            off    <= '0;
            adr_q  <= BASE;
            dat_q  <= '0;
            wd     <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            off    <= off_nxt;
            adr_q  <= adr_nxt;
            dat_q  <= dat_nxt;
            wd     <= wd_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    // Next-state, pointer advance and watchdog logic.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        off_nxt   = off;
        adr_nxt   = adr_q;
        dat_nxt   = dat_q;
        wd_nxt    = wd;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    off_nxt   = s_sof ? '0 : ptr;
                    adr_nxt   = BASE + (s_sof ? '0 : ptr);
                    dat_nxt   = s_data;
                    wd_nxt    = WD_LOAD;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wb_ack_i || (wd == '0)) begin
                    // A timed-out byte still consumes its slot so the frame
                    // stays aligned; ack wins when both land on the same edge.
                    ptr_nxt   = (off == LAST) ? '0 : off + 1'b1;
                    done_nxt  = wb_ack_i && (off == LAST);
                    err_nxt   = !wb_ack_i;
                    wd_nxt    = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    wd_nxt = wd - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign s_ready     = (state == ST_IDLE);
    assign busy        = (state == ST_WRITE);
    assign wb_cyc_o    = busy;
    assign wb_stb_o    = busy;
    assign wb_we_o     = busy;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_onehot(adr_q[1:0]);
    assign frame_done  = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_wb_farbborg_loader.sv
// Directed and randomized bench for wb_farbborg_loader against a frame-offset
// reference model.
module tb_wb_farbborg_loader;

    localparam int FL = 375;
    localparam int TO = 8;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    s_data = '0;
    logic          s_sof = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] wb_adr_o;
    logic [7:0]    wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic          wb_ack_i = 1'b0;
    logic          busy, frame_done, err_timeout;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;   // model: frame offset of the next non-sof byte

    wb_farbborg_loader #(
        .FRAME_LEN(FL), .BASE_ADR(0), .ADR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_ack_i(wb_ack_i), .busy(busy),
        .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one byte; slave acks lat cycles after stb rises (0 = never acks).
    task automatic send_byte(input logic [7:0] d, input logic sof, input int lat);
        int off;
        logic [3:0] sel_e;
        check("ready_before", s_ready, 1);
        check("cyc_before", wb_cyc_o, 0);
        off   = sof ? 0 : ptr_m;
        sel_e = 4'b0001 << (off % 4);
        s_data = d; s_sof = sof; s_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0;
        check("adr", wb_adr_o, off);
        check("dat", wb_dat_o, d);
        check("sel", wb_sel_o, sel_e);
        check("cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
        check("ready_write", s_ready, 0);
        check("busy_write", busy, 1);
        check("pulses_clear", {frame_done, err_timeout}, 2'b00);
        for (int i = 1; i <= TO; i++) begin
            wb_ack_i = (i == lat);
            @(posedge clk); @(negedge clk);
            wb_ack_i = 1'b0;
            if (i == lat) begin
                check("ack_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
                check("ack_ready", s_ready, 1);
                check("ack_busy", busy, 0);
                check("frame_done", frame_done, (off == FL - 1) ? 1 : 0);
                check("ack_no_err", err_timeout, 0);
                break;
            end else if (i == TO) begin
                check("to_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
                check("to_err", err_timeout, 1);
                check("to_no_done", frame_done, 0);
                check("to_ready", s_ready, 1);
            end else begin
                check("hold_cyc", wb_stb_o, 1);
                check("hold_adr", wb_adr_o, off);
                check("hold_no_err", err_timeout, 0);
            end
        end
        ptr_m = (off + 1) % FL;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", s_ready, 1);
        check("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_sel", wb_sel_o, 4'b0001);
        check("rst_busy", busy, 0);
        check("rst_pulses", {frame_done, err_timeout}, 2'b00);
        reset = 1'b0;
        @(negedge clk);

        // Three bytes, first with sof, ack one cycle after stb.
        send_byte(8'h33, 1'b1, 1);
        send_byte(8'h44, 1'b0, 1);
        send_byte(8'h55, 1'b0, 1);

        // Ack while idle must do nothing.
        wb_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        wb_ack_i = 1'b0;
        check("idle_ack_cyc", wb_cyc_o, 0);
        check("idle_ack_pulses", {frame_done, err_timeout}, 2'b00);
        check("idle_ack_ready", s_ready, 1);

        // Full frame, then one more byte that must wrap to offset 0.
        for (int i = 0; i < FL; i++)
            send_byte(8'($urandom), (i == 0), int'($urandom_range(1, 3)));
        send_byte(8'hA5, 1'b0, 1);

        // Slave never acks: watchdog abort, next byte goes to next address.
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 2);

        // Ack on the exact timeout edge.
        send_byte(8'h66, 1'b0, TO);

        // sof at byte 100 mid-frame abandons the partial frame.
        for (int i = 0; i < 100; i++)
            send_byte(8'($urandom), (i == 0), 1);
        send_byte(8'h77, 1'b1, 1);

        // Random mix of sof, ack latency and missing acks.
        for (int i = 0; i < 200; i++)
            send_byte(8'($urandom), ($urandom_range(0, 15) == 0),
                      int'($urandom_range(0, TO)));

        // Reset while stb is high and ack withheld.
        if (ptr_m == 0) send_byte(8'h01, 1'b0, 1);
        s_data = 8'h99; s_sof = 1'b0; s_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        s_valid = 1'b0;
        check("pre_rst_stb", wb_stb_o, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
        check("mid_rst_ready", s_ready, 1);
        check("mid_rst_pulses", {frame_done, err_timeout}, 2'b00);
        check("mid_rst_dat", wb_dat_o, 0);
        reset = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        send_byte(8'hC3, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
